mod_n_counter: RTL
==================

Name: mod_n_counter

Overview:
- Parametrised modulo-N counter, successor to the fixed mod-13 counter.
- Adds up/down direction, enable, synchronous clear and load, and a continuous or one-shot mode with a halt state.
- Provides a cascadable carry output and a saturating wrap counter.
- Used as a timebase/sequencer building block; multiple instances chain via carry -> en.

Parameters:
- MODULUS, 13, count range 0..MODULUS-1; legal range 2..2^WIDTH.
- WIDTH, 4, width of Q and load_val; must satisfy 2^WIDTH >= MODULUS.
- WRAP_W, 8, width of wrap_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low; port keeps the codebase name "reset", and reset==0 resets the block.
- en  in  1  count enable.
- up  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value for load.
- one_shot  in  1  1 = halt at terminal count, 0 = wrap continuously.
- Q  out  WIDTH  count value (registered).
- tc  out  1  terminal count (combinational): Q==MODULUS-1 when up=1; Q==0 when up=0.
- carry  out  1  combinational: tc & en & (state==RUN); cascade into the next stage's en.
- done  out  1  registered; 1 while state==HALT.
- load_err  out  1  registered one-cycle pulse: the previous cycle loaded a value >= MODULUS.
- wrap_cnt  out  WRAP_W  registered count of wraps; saturates at all-ones.

Behaviour:
- Reset (reset==0, asynchronous): Q=0, state=RUN, done=0, load_err=0, wrap_cnt=0. Outputs hold until the first rising clk after reset returns to 1.
- Per-edge priority: clear > load > count.
- clear: Q=0, state=RUN, wrap_cnt=0, load_err=0.
- load:
  - load_val < MODULUS: Q=load_val, state=RUN, load_err=0.
  - load_val >= MODULUS: Q=MODULUS-1, state=RUN, load_err=1 for one cycle.
  - load is accepted regardless of en.
- Count: applies only when en=1, state=RUN and neither clear nor load is asserted.
  - Not at terminal: Q=Q+1 (up) or Q-1 (down).
  - At terminal, one_shot=0: Q wraps to 0 (up) or MODULUS-1 (down); wrap_cnt increments unless saturated.
  - At terminal, one_shot=1: Q holds, state -> HALT, done=1 from the next cycle; wrap_cnt unchanged.
- HALT state: Q frozen and carry=0 regardless of en. Exits to RUN only via clear or load; done falls on that same edge.
- State machine:
  - RUN -> HALT on the terminal-count event in one_shot mode.
  - HALT -> RUN on clear or load.
  - No other transitions.
- Mode and direction changes:
  - one_shot sampled each edge; clearing it while in HALT does not restart the counter.
  - Direction change takes effect on the same edge; tc/carry follow up combinationally.
- No intermediate value outside 0..MODULUS-1 is ever registered. Arithmetic is performed WIDTH+1 bits wide, then compared.
- Latency: Q updates one clk after the qualifying edge. tc/carry have zero latency from Q, up and en.

Decomposition:
- Shared package mod_counter_pkg:
  - state enum {RUN, HALT}.
  - function for the terminal value by direction.
  - default MODULUS/WIDTH constants.
- One natural sub-module: sat_counter, a WRAP_W-bit saturating incrementer with synchronous clear, holding wrap_cnt.
- Count/FSM logic stays in the top module.

Test Plan:
1. Reset low for 2 cycles, release, en=1, up=1, one_shot=0, 30 cycles -> Q sequence 0..12,0..12,0..3. wrap_cnt=2; carry high on the two cycles with Q=12.
2. up=0 from Q=0, en=1 -> Q goes 0 -> 12 -> 11; wrap_cnt increments on the 0 -> 12 transition.
3. one_shot=1, up=1, load 10 -> Q 10,11,12, then holds 12. done=1 from the cycle after Q=12 counted; carry=0 in HALT. load 3 -> done=0, Q=3, counting resumes.
4. load_val=15 -> Q=12, load_err high exactly one cycle. Assert load and clear together -> Q=0 (clear wins).
5. Assert reset low asynchronously mid-count at Q=7, between edges -> Q=0, done=0 and wrap_cnt=0 immediately, without waiting for clk.
6. WRAP_W=2, continuous up for 60 cycles -> wrap_cnt saturates at 3; clear resets it to 0.

Source files
------------

// File: rtl/mod_n_counter_pkg.sv
// Shared types and defaults for the modulo-N counter family.
package mod_counter_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam int DEF_MODULUS = 13;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_WRAP_W  = 8;

  // Value at which the counter reaches its terminal count for a given direction.
  function automatic int unsigned terminal_val(input logic up, input int unsigned modulus);
    if (up) begin
      return modulus - 32'd1;
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/mod_n_counter_if.sv
// Control and status bundle of one modulo-N counter stage.
interface mod_n_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) ();

  logic              en;
  logic              up;
  logic              clear;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              one_shot;
  logic [WIDTH-1:0]  Q;
  logic              tc;
  logic              carry;
  logic              done;
  logic              load_err;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output en, up, clear, load, load_val, one_shot,
    input  Q, tc, carry, done, load_err, wrap_cnt
  );

  modport slave (
    input  en, up, clear, load, load_val, one_shot,
    output Q, tc, carry, done, load_err, wrap_cnt
  );

endinterface

// File: rtl/mod_n_counter_sat_counter.sv
// Saturating incrementer with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next-count selection: clear beats increment, increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with load, clear, one-shot halt, cascade carry and wrap tally.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int WRAP_W  = DEF_WRAP_W
) (
  input logic            clk,
  input logic            reset,
  mod_n_counter_if.slave bus
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  q_d;
  logic              done_q;
  logic              load_err_q;
  logic              load_err_d;
  logic [WIDTH:0]    q_ext_s;
  logic [WIDTH:0]    step_s;
  logic              tc_s;
  logic              run_s;
  logic              count_s;
  logic              wrap_s;
  logic [WRAP_W-1:0] wrap_cnt_s;

  assign tc_s    = (q_q == WIDTH'(terminal_val(bus.up, int'(MODULUS))));
  assign run_s   = (state_q == RUN);
  assign count_s = bus.en & run_s & ~bus.clear & ~bus.load;
  assign wrap_s  = count_s & tc_s & ~bus.one_shot;

  // Next-state selection: clear > load > count; the step is formed one bit wider and range-checked.
  always_comb begin
    q_ext_s    = {1'b0, q_q};
    step_s     = bus.up ? (q_ext_s + ONE_EXT) : (q_ext_s - ONE_EXT);
    q_d        = q_q;
    state_d    = state_q;
    load_err_d = 1'b0;
    if (bus.clear) begin
      q_d     = '0;
      state_d = RUN;
    end else if (bus.load) begin
      state_d = RUN;
      if ({1'b0, bus.load_val} < MOD_EXT) begin
        q_d = bus.load_val;
      end else begin
        q_d        = LAST;
        load_err_d = 1'b1;
      end
    end else if (count_s) begin
      if (!tc_s) begin
        q_d = (step_s < MOD_EXT) ? step_s[WIDTH-1:0] : LAST;
      end else if (bus.one_shot) begin
        state_d = HALT;
      end else if (bus.up) begin
        q_d = '0;
      end else begin
        q_d = LAST;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count, state and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q        <= '0;
      state_q    <= RUN;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      state_q    <= state_d;
      done_q     <= (state_d == HALT);
      load_err_q <= load_err_d;
    end
  end

  sat_counter #(.W(WRAP_W)) u_wrap (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (bus.clear),
    .inc_i (wrap_s),
    .cnt_o (wrap_cnt_s)
  );

  assign bus.Q        = q_q;
  assign bus.tc       = tc_s;
  assign bus.carry    = tc_s & bus.en & run_s;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;
  assign bus.wrap_cnt = wrap_cnt_s;

endmodule
